playback_ctrl: RTL and testbench

Central playback sequencer between the command source (bluetooth decoder pulses) and the mp3 streaming core. It turns one-cycle command pulses into a stable song index, pause flag and SCI volume word. Song changes run through a stop/idle handshake with the mp3 core, so a stream is never cut mid-transfer. It also emits a single song-change strobe that drives the time counter and the VGA cover reload.

---
 rtl/playback_ctrl.sv | 174 +++++++++++++++++
 tb/tb_playback_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_ctrl.sv
// Playback sequencer: turns command pulses into song index, pause and SCI volume,
// and runs song changes through a stop/idle handshake with the mp3 core.
module playback_ctrl #(
    parameter int          NUM_SONGS  = 4,
    parameter int          VOL_LEVELS = 8,
    parameter int          INIT_LEVEL = 4,
    parameter logic [7:0]  VOL_STEP   = 8'h10,
    parameter int          TIMEOUT    = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_next,
    input  logic        i_pre,
    input  logic        i_pause_tgl,
    input  logic        i_vol_plus,
    input  logic        i_vol_dec,
    input  logic        i_finish_song,
    input  logic        i_dec_idle,
    output logic [2:0]  o_song_select,
    output logic        o_pause,
    output logic        o_stop,
    output logic        o_song_change,
    output logic        o_busy,
    output logic [15:0] o_vol,
    output logic [3:0]  vol_level
);

    localparam int             TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMAX      = TW'(TIMEOUT - 1);
    localparam logic [2:0]     LAST_IDX  = 3'(NUM_SONGS - 1);
    localparam logic [3:0]     VMAX      = 4'(VOL_LEVELS);
    localparam logic [3:0]     VINIT     = 4'(INIT_LEVEL);
    localparam logic [11:0]    INIT_PROD = 12'(INIT_LEVEL) * 12'(VOL_STEP);

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_PAUSED   = 2'd1,
        ST_STOP_REQ = 2'd2,
        ST_LOAD     = 2'd3
    } state_t;

    state_t          state_r;
    logic            dir_next_r;
    logic [TW-1:0]   timer_r;

    logic            cmd_dir_valid_s;
    logic            trigger_s;
    logic            trig_dir_next_s;
    logic            eff_dir_next_s;
    logic            stop_done_s;
    logic [2:0]      new_idx_s;
    logic [3:0]      vol_next_s;
    logic [11:0]     prod_s;
    logic [7:0]      att_s;

    // Wrapping step of the song index in either direction.
    function automatic logic [2:0] idx_step(input logic [2:0] idx, input logic fwd);
        logic [2:0] res;
        if (fwd) begin
            res = (idx >= LAST_IDX) ? 3'd0 : idx + 3'd1;
        end else begin
            res = (idx == 3'd0) ? LAST_IDX : idx - 3'd1;
        end
        return res;
    endfunction

    // Command decode: finish-of-file outranks a lone next/pre; next+pre together cancel.
    always_comb begin
        cmd_dir_valid_s = i_next ^ i_pre;
        trigger_s       = i_finish_song | cmd_dir_valid_s;
        trig_dir_next_s = i_finish_song | i_next;
        if (cmd_dir_valid_s) begin
            eff_dir_next_s = i_next;
        end else begin
            eff_dir_next_s = dir_next_r;
        end
        stop_done_s = i_dec_idle | (timer_r == TMAX);
        new_idx_s   = idx_step(o_song_select, eff_dir_next_s);
    end

    // Saturating volume level and its SCI attenuation byte.
    always_comb begin
        vol_next_s = vol_level;
        if (i_vol_plus && !i_vol_dec) begin
            if (vol_level != 4'd0) begin
                vol_next_s = vol_level - 4'd1;
            end else begin
                vol_next_s = 4'd0;
            end
        end else if (i_vol_dec && !i_vol_plus) begin
            if (vol_level < VMAX) begin
                vol_next_s = vol_level + 4'd1;
            end else begin
                vol_next_s = VMAX;
            end
        end else begin
            vol_next_s = vol_level;
        end
        prod_s = 12'(vol_next_s) * 12'(VOL_STEP);
        att_s  = prod_s[7:0];
    end

    // Playback state machine with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_PLAY;
            dir_next_r    <= 1'b1;
            timer_r       <= '0;
            o_song_select <= 3'd0;
            o_pause       <= 1'b0;
            o_stop        <= 1'b0;
            o_song_change <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_PLAY, ST_PAUSED: begin
                    if (trigger_s) begin
                        state_r    <= ST_STOP_REQ;
                        dir_next_r <= trig_dir_next_s;
                        timer_r    <= '0;
                        o_stop     <= 1'b1;
                        o_busy     <= 1'b1;
                    end else if (i_pause_tgl) begin
                        state_r <= (state_r == ST_PLAY) ? ST_PAUSED : ST_PLAY;
                        o_pause <= (state_r == ST_PLAY);
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_STOP_REQ: begin
                    if (cmd_dir_valid_s) begin
                        dir_next_r <= i_next;
                    end else begin
                        dir_next_r <= dir_next_r;
                    end
                    if (stop_done_s) begin
                        state_r       <= ST_LOAD;
                        o_song_select <= new_idx_s;
                        o_song_change <= 1'b1;
                        o_stop        <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_LOAD: begin
                    // Pause survives the switch until the new song starts playing.
                    state_r       <= ST_PLAY;
                    o_song_change <= 1'b0;
                    o_busy        <= 1'b0;
                    o_pause       <= 1'b0;
                end
                default: begin
                    state_r       <= ST_PLAY;
                    o_stop        <= 1'b0;
                    o_song_change <= 1'b0;
                    o_busy        <= 1'b0;
                    o_pause       <= 1'b0;
                end
            endcase
        end
    end

    // Volume registers, both updated from the same next level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_level <= VINIT;
            o_vol     <= {INIT_PROD[7:0], INIT_PROD[7:0]};
        end else begin
            vol_level <= vol_next_s;
            o_vol     <= {att_s, att_s};
        end
    end

endmodule

// File: tb/tb_playback_ctrl.sv
// Scoreboard bench for playback_ctrl: a behavioural model predicts each cycle's
// outputs; a monitor compares them and checks every song-change strobe.
module tb_playback_ctrl;

    localparam int N   = 4;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_next, i_pre, i_pause_tgl, i_vol_plus, i_vol_dec, i_finish_song, i_dec_idle;
    logic [2:0]  o_song_select;
    logic        o_pause, o_stop, o_song_change, o_busy;
    logic [15:0] o_vol;
    logic [3:0]  vol_level;

    always #5 clk = ~clk;

    playback_ctrl #(.NUM_SONGS(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_next(i_next), .i_pre(i_pre), .i_pause_tgl(i_pause_tgl),
        .i_vol_plus(i_vol_plus), .i_vol_dec(i_vol_dec),
        .i_finish_song(i_finish_song), .i_dec_idle(i_dec_idle),
        .o_song_select(o_song_select), .o_pause(o_pause), .o_stop(o_stop),
        .o_song_change(o_song_change), .o_busy(o_busy),
        .o_vol(o_vol), .vol_level(vol_level)
    );

    typedef struct packed {
        logic [2:0]  song;
        logic        pause;
        logic        stop;
        logic        change;
        logic        busy;
        logic [15:0] vol;
        logic [3:0]  lvl;
    } obs_t;

    obs_t exp_q[$];
    int   ev_q[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural model state
    int m_idx, m_vol, m_dir, m_wait;
    bit m_paused, m_switching, m_loading;

    function automatic obs_t dut_obs();
        obs_t o;
        o.song = o_song_select; o.pause = o_pause; o.stop = o_stop;
        o.change = o_song_change; o.busy = o_busy; o.vol = o_vol; o.lvl = vol_level;
        return o;
    endfunction

    function automatic obs_t model_obs(input bit chg);
        obs_t o;
        logic [7:0] att;
        att      = 8'((m_vol * 16) % 256);
        o.song   = 3'(m_idx);
        o.pause  = m_paused;
        o.stop   = m_switching;
        o.change = chg;
        o.busy   = m_switching | m_loading;
        o.vol    = {att, att};
        o.lvl    = 4'(m_vol);
        return o;
    endfunction

    function automatic void show_fail(input string name, input obs_t g, input obs_t e);
        $display("FAIL %s t=%0t got song=%0d pause=%0b stop=%0b chg=%0b busy=%0b vol=%h lvl=%0d / need song=%0d pause=%0b stop=%0b chg=%0b busy=%0b vol=%h lvl=%0d",
                 name, $time, g.song, g.pause, g.stop, g.change, g.busy, g.vol, g.lvl,
                 e.song, e.pause, e.stop, e.change, e.busy, e.vol, e.lvl);
    endfunction

    task automatic model_reset();
        m_idx = 0; m_vol = 4; m_dir = 1; m_wait = 0;
        m_paused = 0; m_switching = 0; m_loading = 0;
    endtask

    // One stimulus cycle: drive at negedge, advance the model, push the expectation.
    task automatic step(input bit nx, input bit pr, input bit tg, input bit pl,
                        input bit dc, input bit fi, input bit id);
        bit chg;
        @(negedge clk);
        i_next = nx; i_pre = pr; i_pause_tgl = tg; i_vol_plus = pl;
        i_vol_dec = dc; i_finish_song = fi; i_dec_idle = id;
        chg = 0;
        if (m_loading) begin
            m_loading = 0;
            m_paused  = 0;
        end else if (m_switching) begin
            if (nx != pr) m_dir = nx ? 1 : -1;
            if (id || m_wait == TMO - 1) begin
                m_idx = (m_idx + m_dir + N) % N;
                m_switching = 0;
                m_loading   = 1;
                chg = 1;
            end else begin
                m_wait++;
            end
        end else if (fi || (nx != pr)) begin
            m_dir = (fi || nx) ? 1 : -1;
            m_switching = 1;
            m_wait = 0;
        end else if (tg) begin
            m_paused = !m_paused;
        end
        if (pl && !dc && m_vol > 0) m_vol--;
        if (dc && !pl && m_vol < 8) m_vol++;
        exp_q.push_back(model_obs(chg));
        if (chg) ev_q.push_back(m_idx);
    endtask

    task automatic idle(input int n, input bit id);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, id);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s got=%0d need=%0d", name, got, need);
        end
    endtask

    task automatic chk_reset(input string name);
        obs_t r;
        r = '{song: 3'd0, pause: 1'b0, stop: 1'b0, change: 1'b0, busy: 1'b0,
              vol: 16'h4040, lvl: 4'd4};
        total++;
        if (dut_obs() !== r) begin
            bad++;
            show_fail(name, dut_obs(), r);
        end
    endtask

    task automatic zero_inputs();
        i_next = 0; i_pre = 0; i_pause_tgl = 0; i_vol_plus = 0;
        i_vol_dec = 0; i_finish_song = 0; i_dec_idle = 0;
    endtask

    // Monitor: compare every predicted cycle and every song-change strobe.
    initial begin
        obs_t e;
        int   ev;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (dut_obs() !== e) begin
                    bad++;
                    show_fail("cycle", dut_obs(), e);
                end
            end
            if (o_song_change === 1'b1) begin
                total++;
                if (ev_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe t=%0t got unexpected song_change idx=%0d need none", $time, o_song_select);
                end else begin
                    ev = ev_q.pop_front();
                    if (int'(o_song_select) != ev) begin
                        bad++;
                        $display("FAIL strobe_idx t=%0t got=%0d need=%0d", $time, o_song_select, ev);
                    end
                end
            end
        end
    end

    initial begin
        zero_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset("reset_values");

        // next at cycle 10, idle at the fifth stop cycle
        idle(9, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(4, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3, 0);
        settle();
        chk("first_next_idx", o_song_select, 1);

        // two pre with idle held high, then end-of-file
        step(0, 1, 0, 0, 0, 0, 1);
        idle(4, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        idle(4, 1);
        settle();
        chk("pre_wrap_idx", o_song_select, 3);
        step(0, 0, 0, 0, 0, 1, 1);
        idle(4, 1);
        settle();
        chk("finish_wrap_idx", o_song_select, 0);

        // timeout with direction overwritten by pre mid-wait
        step(1, 0, 0, 0, 0, 0, 0);
        idle(20, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(85, 0);
        settle();
        chk("timeout_idx", o_song_select, 3);

        // volume saturation
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("vol_max_level", vol_level, 8);
        chk("vol_max_word", o_vol, 16'h8080);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("vol_min_level", vol_level, 0);
        chk("vol_min_word", o_vol, 16'h0000);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        settle();
        chk("vol_both", vol_level, 1);

        // pause, then switch clears pause
        step(0, 0, 1, 0, 0, 0, 0);
        idle(1, 0);
        settle();
        chk("paused", o_pause, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2, 0);
        settle();
        chk("pause_cleared", o_pause, 0);

        // next+pre together ignored
        step(1, 1, 0, 0, 0, 0, 1);
        settle();
        chk("next_pre_ignored", o_stop, 0);

        // reset mid-switch
        step(1, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        @(negedge clk);
        zero_inputs();
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_mid_switch");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(5, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) == 0);
        end
        idle(4, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        chk("events_drained", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
